// File: rtl/uart_tx_seq.sv
// Message sequencer feeding a UART transmitter: plays len characters out of a
// small write-only buffer, one per transmitter-empty handshake, with optional looping.
`timescale 1ns/1ps
module uart_tx_seq #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              go,
  input  logic              rpt,
  input  logic [AW:0]       len,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tdre,
  output logic              ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] WTGO   = 3'd0;
  localparam logic [2:0] WTTDRE = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] WTACK  = 3'd3;
  localparam logic [2:0] WTNGO  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [AW:0]       idx_q, idx_d;
  logic [AW:0]       len_q, len_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // Message buffer: no reset, and frozen while a message is in flight.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state and output decode for the handshake sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    busy_d    = busy_q;
    tx_data_d = tx_data_q;
    case (state_q)
      WTGO: begin
        if (go) begin
          len_d = len;
          idx_d = {(AW+1){1'b0}};
          if (len == {(AW+1){1'b0}}) begin
            done_d  = 1'b1;
            state_d = WTNGO;
          end else begin
            busy_d  = 1'b1;
            state_d = WTTDRE;
          end
        end else begin
          state_d = WTGO;
        end
      end
      WTTDRE: begin
        // Also re-raises busy on the first cycle of a repeated pass.
        busy_d = 1'b1;
        if (tdre) begin
          state_d = LOAD;
        end else begin
          state_d = WTTDRE;
        end
      end
      LOAD: begin
        ready_d   = 1'b1;
        tx_data_d = mem_q[idx_q[AW-1:0]];
        idx_d     = idx_q + {{AW{1'b0}}, 1'b1};
        state_d   = WTACK;
      end
      WTACK: begin
        if (!tdre) begin
          if (idx_q < len_q) begin
            state_d = WTTDRE;
          end else begin
            done_d = 1'b1;
            busy_d = 1'b0;
            if (rpt && go) begin
              idx_d   = {(AW+1){1'b0}};
              state_d = WTTDRE;
            end else begin
              state_d = WTNGO;
            end
          end
        end else begin
          state_d = WTACK;
        end
      end
      WTNGO: begin
        if (go) begin
          state_d = WTNGO;
        end else begin
          state_d = WTGO;
        end
      end
      default: begin
        state_d = WTGO;
        busy_d  = 1'b0;
        idx_d   = {(AW+1){1'b0}};
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by clr.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q   <= WTGO;
      idx_q     <= {(AW+1){1'b0}};
      len_q     <= {(AW+1){1'b0}};
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tx_data_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign ready   = ready_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx_seq.sv
// Bench for uart_tx_seq: an expected-character queue built from a buffer model,
// a transmitter model that acknowledges loads, and directed latency/boundary checks.
`timescale 1ns/1ps
module tb_uart_tx_seq;
  logic       clk = 1'b0;
  logic       clr, go, rpt, wr_en, tdre, ready, busy, done;
  logic [4:0] len;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, tx_data;

  logic [7:0] mem [16];
  logic [7:0] exp_q [$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  bit   ack_en = 1'b1;

  uart_tx_seq #(.DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .clr(clr), .go(go), .rpt(rpt), .len(len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .tdre(tdre),
    .ready(ready), .tx_data(tx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_msg(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
  endtask

  task automatic wr(input int a, input logic [7:0] d, input bit taken);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[3:0]; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (taken) mem[a] = d;
  endtask

  task automatic wait_done(input int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("done_timeout", (k < bound), 1);
  endtask

  // Transmitter: takes each load, holds tdre low for two cycles, then empties.
  task automatic xmtr();
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (ack_en && ready && !clr) begin
        tdre = 1'b0; cnt = 2;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tdre = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    logic pr = 1'b0;
    logic pd = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (clr) begin
        pr = 1'b0; pd = 1'b0;
      end else begin
        if (ready) begin
          if (exp_q.size() == 0) chk("unexpected_ready", ready, 0);
          else begin
            e = exp_q.pop_front();
            chk("tx_data", tx_data, e);
          end
          chk("ready_width", pr, 0);
        end
        if (done) begin
          done_cnt++;
          chk("done_busy_low", busy, 0);
          chk("done_width", pd, 0);
        end
        pr = ready; pd = done;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    clr = 1'b1; go = 1'b0; rpt = 1'b0; len = 5'd0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; tdre = 1'b1;
    fork
      xmtr();
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tx_data", tx_data, 0);
    clr = 1'b0;
    for (int i = 0; i < 16; i++) wr(i, 8'h48 + 8'(i), 1'b1);
    chk("model_h", mem[0], 8'h48);
    chk("model_i", mem[1], 8'h49);

    // "HI": latency on first and second character.
    len = 5'd2; expect_msg(2);
    @(negedge clk); go = 1'b1;
    @(posedge clk); #1; chk("t1_busy", busy, 1); chk("t1_e0_ready", ready, 0);
    @(posedge clk); #1; chk("t1_e1_ready", ready, 0);
    @(posedge clk); #1; chk("t1_e2_ready", ready, 1); chk("t1_first", tx_data, 8'h48);
    for (k = 0; k < 20; k++) begin
      @(posedge clk);
      if (tdre) break;
    end
    chk("t1_tdre_back", (k < 20), 1);
    #1; chk("t1_rise_ready", ready, 0);
    @(posedge clk); #1; chk("t1_second_ready", ready, 1); chk("t1_second", tx_data, 8'h49);
    wait_done(100);
    chk("t1_busy_end", busy, 0);
    @(negedge clk); go = 1'b0;
    repeat (5) @(negedge clk);
    chk("t1_hold_tx", tx_data, 8'h49);
    exp_done += 1;
    chk("t1_left", exp_q.size(), 0); chk("t1_dones", done_cnt, exp_done);

    // len=3, go held, no repeat; then re-arm.
    len = 5'd3; expect_msg(3);
    @(negedge clk); go = 1'b1;
    wait_done(200);
    repeat (30) @(negedge clk);
    chk("t2_idle_busy", busy, 0);
    chk("t2_left", exp_q.size(), 0);
    go = 1'b0;
    repeat (2) @(negedge clk);
    expect_msg(3); go = 1'b1;
    wait_done(200);
    @(negedge clk); go = 1'b0;
    repeat (3) @(negedge clk);
    exp_done += 2;
    chk("t2_dones", done_cnt, exp_done);

    // Repeat mode for three passes; write during busy is dropped.
    rpt = 1'b1; len = 5'd2; expect_msg(2); expect_msg(2); expect_msg(2);
    @(negedge clk); go = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_busy_wr", busy, 1);
    wr(0, 8'hFF, 1'b0);
    wait_done(200);
    @(posedge clk); #1; chk("t3_rebusy", busy, 1);
    wait_done(200);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (ready) break;
    end
    chk("t3_pass3_start", (k < 50), 1);
    go = 1'b0;
    wait_done(200);
    repeat (30) @(negedge clk);
    rpt = 1'b0;
    exp_done += 3;
    chk("t3_left", exp_q.size(), 0); chk("t3_dones", done_cnt, exp_done);

    // len=0 then len=DEPTH.
    len = 5'd0;
    @(negedge clk); go = 1'b1;
    @(posedge clk); #1; chk("t5_done", done, 1); chk("t5_ready", ready, 0); chk("t5_busy", busy, 0);
    @(posedge clk); #1; chk("t5_done_fall", done, 0);
    @(negedge clk); go = 1'b0;
    repeat (2) @(negedge clk);
    len = 5'd16; expect_msg(16);
    chk("model_last", exp_q[15], 8'h57);
    go = 1'b1;
    wait_done(600);
    @(negedge clk); go = 1'b0;
    repeat (5) @(negedge clk);
    exp_done += 2;
    chk("t5_left", exp_q.size(), 0); chk("t5_dones", done_cnt, exp_done);

    // No acknowledge: one load only; clr abandons; restart at index 0.
    ack_en = 1'b0; len = 5'd2; expect_msg(1);
    @(negedge clk); go = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6_stuck_busy", busy, 1);
    chk("t6_one_load", exp_q.size(), 0);
    #2; clr = 1'b1;
    #1; chk("t6_clr_ready", ready, 0); chk("t6_clr_busy", busy, 0);
    chk("t6_clr_done", done, 0); chk("t6_clr_tx", tx_data, 0);
    go = 1'b0; ack_en = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    expect_msg(2); go = 1'b1;
    @(posedge clk); #1; chk("t6_e0_ready", ready, 0);
    @(posedge clk); #1; chk("t6_e1_ready", ready, 0);
    @(posedge clk); #1; chk("t6_e2_ready", ready, 1); chk("t6_restart", tx_data, 8'h48);
    wait_done(100);
    @(negedge clk); go = 1'b0;
    repeat (5) @(negedge clk);
    exp_done += 1;
    chk("t6_left", exp_q.size(), 0); chk("t6_dones", done_cnt, exp_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_tx_seq.md
UART_TX_SEQ -- requirements
Module: uart_tx_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning character width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, meaning message buffer entries; power of two, 2..256.
REQ-003 SHALL have parameter AW, default log2(DEPTH), meaning buffer address width.
REQ-004 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-005 SHALL have port clr  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port go  in  1  send request, level; start on go=1, re-arm after go=0.
REQ-007 SHALL have port rpt  in  1  repeat mode; message loops while go held.
REQ-008 SHALL have port len  in  AW+1  message length in characters, 0..DEPTH.
REQ-009 SHALL have port wr_en  in  1  buffer write strobe.
REQ-010 SHALL have port wr_addr  in  AW  buffer write address.
REQ-011 SHALL have port wr_data  in  DATA_W  buffer write data.
REQ-012 SHALL have port tdre  in  1  transmitter data register empty, from UART transmitter.
REQ-013 SHALL have port ready  out  1  one-cycle load strobe to transmitter.
REQ-014 SHALL have port tx_data  out  DATA_W  character presented with ready.
REQ-015 SHALL have port busy  out  1  high from go acceptance until message end.
REQ-016 SHALL have port done  out  1  one-cycle pulse at message end.

Function
REQ-017 SHALL implement states WTGO, WTTDRE, LOAD, WTACK, WTNGO; all outputs registered.
REQ-018 WTGO: go=0 -> stay; go=1 with len>0 -> capture len into len_q, idx<=0, busy<=1, go to WTTDRE.
REQ-019 WTGO with go=1 and len=0 SHALL skip all loads, pulse done one cycle later, and go to WTNGO.
REQ-020 WTTDRE: tdre=0 -> stay; tdre=1 -> go to LOAD.
REQ-021 LOAD: ready<=1 for exactly one cycle, tx_data<=buf[idx], idx<=idx+1, go to WTACK.
REQ-022 WTACK: wait for tdre=0, the transmitter acknowledging the load, so one character never loads twice.
REQ-023 WTACK exit: tdre=0 and idx<len_q -> WTTDRE.
REQ-024 WTACK exit: tdre=0 and idx=len_q -> done pulse, busy<=0; then rpt=1 and go=1 -> idx<=0, busy<=1 next cycle, go to WTTDRE; otherwise go to WTNGO.
REQ-025 WTNGO: go=1 -> stay; go=0 -> WTGO. A held go SHALL never start a second message unless rpt=1.
REQ-026 Latency SHALL be exactly 2 cycles from go=1 (with tdre=1) to ready=1.
REQ-027 Latency SHALL be exactly 2 cycles from tdre rising in WTTDRE to ready for subsequent characters.
REQ-028 Buffer SHALL be written only when wr_en=1 and busy=0; writes while busy=1 are dropped.
REQ-029 Changes to len or rpt while busy SHALL not affect the current pass; rpt is sampled at message end.
REQ-030 idx width SHALL be AW+1 so len=DEPTH completes without wrap; idx never exceeds len_q.
REQ-031 tx_data SHALL hold its last value between loads.
REQ-032 go deasserting mid-message SHALL not abort; the message completes, then WTNGO exits to WTGO on the next cycle.

Reset
REQ-033 clr=1 SHALL immediately force state=WTGO, ready=0, busy=0, done=0, idx=0, len_q=0, tx_data=0.
REQ-034 Buffer contents SHALL be unaffected by clr.
REQ-035 clr mid-message SHALL abandon the message with no further ready pulses; a new go after release restarts at index 0.

Verification
REQ-036 Write "HI" (0x48,0x49) at 0,1; len=2, tdre=1 toggling per load; go=1 -> two ready pulses with 0x48 then 0x49, one done, busy low after done.
REQ-037 len=3, go held, rpt=0 -> exactly 3 ready pulses; no restart until go=0 then go=1.
REQ-038 len=2, rpt=1, go held for 3 passes -> ready sequence 0x48,0x49 repeated 3 times with 3 done pulses; drop go -> current pass completes, then stop.
REQ-039 tdre held 1 after a load (no ack) -> exactly one ready pulse, FSM stays in WTACK; clr -> all outputs 0, state WTGO.
REQ-040 len=0, go=1 -> no ready, done after 1 cycle; len=DEPTH=16 -> 16 loads from addresses 0..15, no wrap.
REQ-041 wr_en at address 0 with 0xFF during busy -> ignored, next pass still sends original byte.
